sdram_arbit: RTL and testbench

Command arbiter and output multiplexer that sits between the SDRAM sub-controllers (initialisation, auto-refresh, write and read) and the SDRAM pins inside the SDRAM controller. After initialisation it grants the shared command/address/data bus to exactly one of auto-refresh, write or read at a time. Auto-refresh always has top priority. It drives the chip command, bank, address and data-enable signals from the granted source, and flags a hung sub-controller with a timeout.

---
 rtl/sdram_arbit.sv | 175 +++++++++++++++++
 tb/tb_sdram_arbit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants the shared command/address/data bus to refresh, write or read.
// Optional macro SDRAM_ARBIT_RR_EN: alternate write/read grants when both request at once.
module sdram_arbit #(
  parameter int         TIMEOUT_CYC = 1023,
  parameter logic [3:0] NOP_CMD     = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        arb_err
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARBIT = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYC - 1);

  logic [2:0] state_reg, state_next;
  logic [9:0] cnt_reg, cnt_next;
  logic       grant_act;
  logic       end_hit;
  logic       timeout_hit;
  logic [3:0] cmd_mux;

  assign grant_act = (state_reg == ST_AREF) || (state_reg == ST_WRITE) || (state_reg == ST_READ);

  // Only the granted source's end pulse counts; others are ignored.
  always_comb begin
    end_hit = 1'b0;
    case (state_reg)
      ST_AREF:  end_hit = aref_end;
      ST_WRITE: end_hit = wr_end;
      ST_READ:  end_hit = rd_end;
      default:  end_hit = 1'b0;
    endcase
  end

  assign timeout_hit = grant_act && (cnt_reg == CNT_LAST);

`ifdef SDRAM_ARBIT_RR_EN
  logic last_grant_reg, last_grant_next;

  always_comb begin
    last_grant_next = last_grant_reg;
    if (state_reg == ST_ARBIT) begin
      if (state_next == ST_WRITE) last_grant_next = 1'b0;
      else if (state_next == ST_READ) last_grant_next = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) last_grant_reg <= 1'b1;
    else         last_grant_reg <= last_grant_next;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: begin
        if (init_end) state_next = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_next = ST_AREF;
`ifdef SDRAM_ARBIT_RR_EN
        end else if (wr_req && rd_req) begin
          state_next = last_grant_reg ? ST_WRITE : ST_READ;
`endif
        end else if (wr_req) begin
          state_next = ST_WRITE;
        end else if (rd_req) begin
          state_next = ST_READ;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (end_hit || timeout_hit) state_next = ST_ARBIT;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Counts cycles spent in the current grant; restarts from zero on every new grant.
  assign cnt_next = (grant_act && (state_next == state_reg)) ? cnt_reg + 10'd1 : 10'd0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= 10'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign aref_en   = (state_reg == ST_AREF);
  assign wr_en     = (state_reg == ST_WRITE);
  assign rd_en     = (state_reg == ST_READ);
  assign sdram_cke = 1'b1;
  assign arb_err   = timeout_hit && !end_hit;

  always_comb begin
    cmd_mux    = NOP_CMD;
    sdram_ba   = 2'b11;
    sdram_addr = 13'h1fff;
    case (state_reg)
      ST_INIT: begin
        cmd_mux    = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd_mux    = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux    = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        cmd_mux    = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd_mux    = NOP_CMD;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1fff;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

  assign dq_oe  = wr_sdram_en && (state_reg == ST_WRITE);
  assign dq_out = dq_oe ? wr_sdram_data : 16'h0000;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios followed by random traffic, all checked
// against a bus-ownership model (who owns the bus, for how long, who was served last).
module tb_sdram_arbit;

  localparam int TO = 16;

  logic        sys_clk, sys_rst, init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] dq_out;
  logic        dq_oe, arb_err;

  int total = 0;
  int bad   = 0;

  sdram_arbit #(.TIMEOUT_CYC(TO), .NOP_CMD(4'b0111)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .arb_err(arb_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Bus-ownership model: owner 0=initialising, 1=nobody, 2=refresh, 3=write, 4=read.
  int   owner = 0;
  int   age = 0;
  logic served_read = 1'b1;
  logic model_ok = 1'b0;

  function automatic logic owner_done();
    return (owner == 2 && aref_end) || (owner == 3 && wr_end) || (owner == 4 && rd_end);
  endfunction

  task automatic model_advance();
    if (sys_rst) begin
      owner = 0; age = 0; served_read = 1'b1; model_ok = 1'b1;
    end else if (owner == 0) begin
      if (init_end) owner = 1;
    end else if (owner == 1) begin
      age = 0;
      if (aref_req) owner = 2;
`ifdef SDRAM_ARBIT_RR_EN
      else if (wr_req && rd_req) owner = served_read ? 3 : 4;
`endif
      else if (wr_req) owner = 3;
      else if (rd_req) owner = 4;
      if (owner == 3) served_read = 1'b0;
      if (owner == 4) served_read = 1'b1;
    end else begin
      if (owner_done() || age == TO - 1) begin
        owner = 1; age = 0;
      end else begin
        age = age + 1;
      end
    end
  endtask

  function automatic logic [40:0] model_pins();
    logic [3:0] c; logic [1:0] b; logic [12:0] a; logic oe; logic err;
    c = 4'b0111; b = 2'b11; a = 13'h1fff;
    if (owner == 0) begin c = init_cmd; b = init_ba; a = init_addr; end
    if (owner == 2) begin c = aref_cmd; b = aref_ba; a = aref_addr; end
    if (owner == 3) begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
    if (owner == 4) begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
    oe  = (owner == 3) && wr_sdram_en;
    err = (owner >= 2) && (age == TO - 1) && !owner_done();
    return {owner == 2, owner == 3, owner == 4, 1'b1, c, b, a, oe,
            oe ? wr_sdram_data : 16'h0000, err};
  endfunction

  function automatic logic [40:0] dut_pins();
    return {aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n,
            sdram_we_n, sdram_ba, sdram_addr, dq_oe, dq_out, arb_err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, then crosses one clock edge.
  task automatic clk_step();
    #1;
    if (model_ok) chk("pins", 64'(dut_pins()), 64'(model_pins()));
    @(posedge sys_clk);
    model_advance();
    #1;
  endtask

  task automatic wait_wr_rd(output logic got_rd);
    int n = 0;
    while (!(wr_en || rd_en) && n < 10) begin
      clk_step();
      n++;
    end
    chk("grant_wait", 64'(wr_en | rd_en), 64'd1);
    got_rd = rd_en;
  endtask

  logic [3:0] seq;
  logic [3:0] seq_exp;
  logic       got_rd;
  int         err_cnt, err_at;

  initial begin
    {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = '0;
    init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0000;
    wr_cmd   = 4'b0100; wr_ba   = 2'b10; wr_addr   = 13'h0123;
    rd_cmd   = 4'b0101; rd_ba   = 2'b01; rd_addr   = 13'h0456;
    wr_sdram_data = 16'h0000;

    // Reset, then init_end raised at cycle 10.
    sys_rst = 1'b1;
    clk_step();
    clk_step();
    chk("rst_flags", 64'({aref_en, wr_en, rd_en, arb_err, dq_oe, sdram_cke}), 64'b000001);
    chk("rst_cmd", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}),
        64'({4'b0010, 2'b01, 13'h0400}));
    sys_rst = 1'b0;
    repeat (9) clk_step();
    chk("init_pins", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 64'(4'b0010));
    init_end = 1'b1;
    clk_step();
    chk("nop_pins", 64'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}),
        64'({4'b0111, 2'b11, 13'h1fff}));

    // Refresh beats a simultaneous write; write follows after one NOP cycle.
    aref_req = 1'b1; wr_req = 1'b1;
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA55A;
    clk_step();
    chk("aref_first", 64'({aref_en, wr_en}), 64'b10);
    aref_req = 1'b0;
    clk_step();
    aref_end = 1'b1;
    clk_step();
    aref_end = 1'b0;
    chk("aref_release", 64'({aref_en, wr_en, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}),
        64'(6'b000111));
    clk_step();
    chk("wr_after_aref", 64'(wr_en), 64'd1);
    chk("dq_drive", 64'({dq_oe, dq_out}), 64'({1'b1, 16'hA55A}));
    wr_req = 1'b0;
    wr_end = 1'b1;
    clk_step();
    wr_end = 1'b0;
    rd_req = 1'b1;
    clk_step();
    rd_req = 1'b0;
    chk("rd_dq_off", 64'({rd_en, dq_oe, dq_out}), 64'({1'b1, 1'b0, 16'h0000}));
    rd_end = 1'b1;
    clk_step();
    rd_end = 1'b0;
    wr_sdram_en = 1'b0;

    // Both requests held: four grants.
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_wr_rd(got_rd);
      seq[g] = got_rd;
      $display("grant %0d: %s", g, got_rd ? "read" : "write");
      if (got_rd) rd_end = 1'b1; else wr_end = 1'b1;
      clk_step();
      rd_end = 1'b0; wr_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
    seq_exp = 4'b1010;
`else
    seq_exp = 4'b0000;
`endif
    chk("grant_order", 64'(seq), 64'(seq_exp));
    clk_step();

    // Read that never ends: single arb_err on the 16th grant cycle.
    rd_req = 1'b1;
    clk_step();
    rd_req = 1'b0;
    chk("to_grant", 64'(rd_en), 64'd1);
    err_cnt = 0; err_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (arb_err) begin err_cnt++; err_at = k; end
      if (k == 17) chk("to_release", 64'(rd_en), 64'd0);
      clk_step();
    end
    $display("timeout: pulses=%0d at grant cycle %0d", err_cnt, err_at);
    chk("to_count", 64'(err_cnt), 64'd1);
    chk("to_cycle", 64'(err_at), 64'd16);

    // Reset during a write aborts it immediately.
    wr_req = 1'b1; wr_sdram_en = 1'b1;
    clk_step();
    wr_req = 1'b0;
    chk("wr_before_rst", 64'({wr_en, dq_oe}), 64'b11);
    sys_rst = 1'b1;
    clk_step();
    sys_rst = 1'b0;
    chk("rst_mid_write", 64'({wr_en, dq_oe, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}),
        64'({2'b00, 4'b0010}));
    clk_step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      sys_rst   = ($urandom_range(0, 149) == 0);
      init_end  = ($urandom_range(0, 3) != 0);
      aref_req  = ($urandom_range(0, 7) == 0);
      wr_req    = ($urandom_range(0, 2) == 0);
      rd_req    = ($urandom_range(0, 2) == 0);
      aref_end  = ($urandom_range(0, 9) == 0);
      wr_end    = ($urandom_range(0, 9) == 0);
      rd_end    = ($urandom_range(0, 9) == 0);
      wr_sdram_en   = 1'($urandom);
      wr_sdram_data = 16'($urandom);
      init_cmd = 4'($urandom); init_ba = 2'($urandom); init_addr = 13'($urandom);
      aref_cmd = 4'($urandom); aref_ba = 2'($urandom); aref_addr = 13'($urandom);
      wr_cmd   = 4'($urandom); wr_ba   = 2'($urandom); wr_addr   = 13'($urandom);
      rd_cmd   = 4'($urandom); rd_ba   = 2'($urandom); rd_addr   = 13'($urandom);
      clk_step();
    end
    clk_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
